regfile_access_ctrl: RTL

- Controller in front of the 32x32 register file (2 combinational read ports, 1 write port, no internal bypass, x0 reads 0).
- After reset it sequences a zero-clear of x1..x31.
- Afterwards it shares the ports between the pipeline (priority) and a debug/loader requester, using a starvation counter.
- Sits between decode/writeback and register_file; the debug side connects to the test/debug harness.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_access_ctrl_if.sv | 34 +++
 rtl/regfile_dbg_arbiter.sv | 51 +++++
 rtl/regfile_access_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, FSM state and debug op encoding for the
// register file access controller.
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int AW       = $clog2(NREGS);
    localparam int WCW      = 4;
    localparam int MAX_WAIT = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef enum logic {
        DBG_READ  = 1'b0,
        DBG_WRITE = 1'b1
    } dbg_op_e;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Debug/loader request-response channel into the register file
// access controller.
interface regfile_access_ctrl_if;
    import regfile_pkg::*;

    logic            dbg_req_valid;
    logic            dbg_req_ready;
    logic            dbg_write;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_wdata;
    logic            dbg_rsp_valid;
    logic [XLEN-1:0] dbg_rdata;

    modport master (
        output dbg_req_valid,
        output dbg_write,
        output dbg_addr,
        output dbg_wdata,
        input  dbg_req_ready,
        input  dbg_rsp_valid,
        input  dbg_rdata
    );

    modport slave (
        input  dbg_req_valid,
        input  dbg_write,
        input  dbg_addr,
        input  dbg_wdata,
        output dbg_req_ready,
        output dbg_rsp_valid,
        output dbg_rdata
    );

endinterface

// File: rtl/regfile_dbg_arbiter.sv
// Grant, stall and starvation-counter logic sharing the register
// file ports between the pipeline and the debug requester.
module regfile_dbg_arbiter
    import regfile_pkg::*;
#(
    parameter int MAX_WAIT_P = MAX_WAIT
) (
    input  logic           run_i,
    input  logic           pl_valid_i,
    input  logic           pl_we_i,
    input  logic           req_valid_i,
    input  logic           req_write_i,
    input  logic [WCW-1:0] wait_cnt_i,
    output logic           grant_o,
    output logic           stall_o,
    output logic [WCW-1:0] wait_cnt_d_o
);

    logic at_max;
    logic rd_ok;
    logic wr_ok;
    logic is_wr;
    logic drain;

    assign at_max = (wait_cnt_i == WCW'(MAX_WAIT_P));
    assign is_wr  = (dbg_op_e'(req_write_i) == DBG_WRITE);
    assign rd_ok  = !pl_valid_i || at_max;
    assign wr_ok  = !pl_we_i && rd_ok;

    assign grant_o = run_i && req_valid_i
                   && (is_wr ? wr_ok : rd_ok);

    // A starved write held off only by writeback stalls decode so
    // the writeback stream drains and the write can get in.
    assign drain = run_i && req_valid_i && is_wr
                 && at_max && pl_we_i;

    assign stall_o = !run_i
                   || (grant_o && pl_valid_i)
                   || drain;

    always_comb begin
        wait_cnt_d_o = wait_cnt_i;
        if (!req_valid_i || grant_o) begin
            wait_cnt_d_o = '0;
        end else if (!at_max) begin
            wait_cnt_d_o = wait_cnt_i + WCW'(1);
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register file front end: post-reset zero clear, then pipeline
// access with a starvation-bounded debug/loader port.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int MAX_WAIT_P = MAX_WAIT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pl_valid,
    input  logic [AW-1:0]   pl_rs1,
    input  logic [AW-1:0]   pl_rs2,
    output logic [XLEN-1:0] pl_data_rs1,
    output logic [XLEN-1:0] pl_data_rs2,
    input  logic            pl_we,
    input  logic [AW-1:0]   pl_rd,
    input  logic [XLEN-1:0] pl_data_rd,
    output logic            pl_stall,
    regfile_access_ctrl_if.slave dbg,
    output logic [AW-1:0]   rf_addr_rs1,
    output logic [AW-1:0]   rf_addr_rs2,
    input  logic [XLEN-1:0] rf_data_rs1,
    input  logic [XLEN-1:0] rf_data_rs2,
    output logic [AW-1:0]   rf_addr_rd,
    output logic [XLEN-1:0] rf_data_rd,
    output logic            rf_write_enable,
    output logic            init_done
);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic            init_done_q, init_done_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic grant;
    logic stall;
    logic run;
    logic is_wr;

    assign run   = (state_q == RUN) && !reset;
    assign is_wr = (dbg_op_e'(dbg.dbg_write) == DBG_WRITE);

    regfile_dbg_arbiter #(
        .MAX_WAIT_P (MAX_WAIT_P)
    ) u_arb (
        .run_i        (run),
        .pl_valid_i   (pl_valid),
        .pl_we_i      (pl_we),
        .req_valid_i  (dbg.dbg_req_valid),
        .req_write_i  (dbg.dbg_write),
        .wait_cnt_i   (wait_cnt_q),
        .grant_o      (grant),
        .stall_o      (stall),
        .wait_cnt_d_o (wait_cnt_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_idx_q   <= AW'(1);
            wait_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        clr_idx_d       = clr_idx_q;
        init_done_d     = init_done_q;
        rsp_valid_d     = 1'b0;
        rdata_d         = rdata_q;
        rf_addr_rs1     = pl_rs1;
        rf_addr_rs2     = pl_rs2;
        rf_addr_rd      = pl_rd;
        rf_data_rd      = pl_data_rd;
        rf_write_enable = pl_we;
        unique case (state_q)
            CLEAR: begin
                rf_write_enable = 1'b1;
                rf_addr_rd      = clr_idx_q;
                rf_data_rd      = '0;
                clr_idx_d       = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (grant) begin
                    rsp_valid_d = 1'b1;
                    if (is_wr) begin
                        rf_addr_rd      = dbg.dbg_addr;
                        rf_data_rd      = dbg.dbg_wdata;
                        rf_write_enable = |dbg.dbg_addr;
                        rdata_d         = '0;
                    end else begin
                        rf_addr_rs1 = dbg.dbg_addr;
                        rdata_d     = (dbg.dbg_addr == '0)
                                    ? '0 : rf_data_rs1;
                    end
                end
            end
            default: ;
        endcase
        // Reset is asynchronous: no write may escape while it is held.
        if (reset) begin
            rf_write_enable = 1'b0;
        end
    end

    assign pl_data_rs1       = rf_data_rs1;
    assign pl_data_rs2       = rf_data_rs2;
    assign pl_stall          = stall;
    assign init_done         = init_done_q;
    assign dbg.dbg_req_ready = grant;
    assign dbg.dbg_rsp_valid = rsp_valid_q;
    assign dbg.dbg_rdata     = rdata_q;

endmodule
